// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector and its window counter.
package seq_det_pkg;

  localparam int DEF_PAT_W = 9;
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 9'b011101010;

  localparam int CNT_MAX = (1 << DEF_CNT_W) - 1;

  // Fill counter must hold 0..pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/match_window_counter.sv
// Saturating per-window match counter with a sticky saturation flag, latched
// into display registers (and cleared) on each window tick.
module match_window_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_disp_count,
  output logic             o_disp_valid,
  output logic             o_disp_sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] disp_count_q, disp_count_d;
  logic             disp_valid_q, disp_valid_d;
  logic             disp_sat_q, disp_sat_d;

  logic             at_max;
  logic [CNT_W-1:0] cnt_upd;
  logic             sat_upd;

  always_comb begin
    at_max  = (count_q == MAX_CNT);
    cnt_upd = (i_inc && !at_max) ? count_q + CNT_W'(1) : count_q;
    sat_upd = sat_q | (i_inc & at_max);

    // The closing window includes any match or saturation arriving with the tick.
    count_d      = cnt_upd;
    sat_d        = sat_upd;
    disp_count_d = disp_count_q;
    disp_sat_d   = disp_sat_q;
    disp_valid_d = i_tick;
    if (i_tick) begin
      count_d      = '0;
      sat_d        = 1'b0;
      disp_count_d = cnt_upd;
      disp_sat_d   = sat_upd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q      <= '0;
      sat_q        <= 1'b0;
      disp_count_q <= '0;
      disp_valid_q <= 1'b0;
      disp_sat_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      sat_q        <= sat_d;
      disp_count_q <= disp_count_d;
      disp_valid_q <= disp_valid_d;
      disp_sat_q   <= disp_sat_d;
    end
  end

  assign o_count      = count_q;
  assign o_disp_count = disp_count_q;
  assign o_disp_valid = disp_valid_q;
  assign o_disp_sat   = disp_sat_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Detects a runtime-loadable PAT_W-bit pattern in a qualified serial stream
// (MSB received first) and feeds matches to a tick-windowed counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                PAT_W       = DEF_PAT_W,
  parameter int                CNT_W       = DEF_CNT_W,
  parameter logic [PAT_W-1:0]  DEF_PATTERN = PAT_W'(seq_det_pkg::DEF_PATTERN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit_valid,
  input  logic             i_bit_seq,
  input  logic             i_pat_load,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_overlap,
  input  logic             i_tick,
  output logic             o_seq_detected,
  output logic [CNT_W-1:0] o_match_count,
  output logic [CNT_W-1:0] o_disp_count,
  output logic             o_disp_valid,
  output logic             o_disp_sat
);

  localparam int FILL_W = fill_w(PAT_W);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  shift_q, shift_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q;

  logic [PAT_W-1:0]  shift_nxt;
  logic              sample;
  logic              hit;

  always_comb begin
    shift_nxt = {shift_q[PAT_W-2:0], i_bit_seq};
    // A load strobe swallows any bit presented alongside it.
    sample    = i_bit_valid & ~i_pat_load;
    hit       = sample && (fill_q >= FILL_LAST) && (shift_nxt == pattern_q);

    pattern_d = pattern_q;
    shift_d   = shift_q;
    fill_d    = fill_q;

    if (i_pat_load) begin
      pattern_d = i_pattern;
      fill_d    = '0;
    end else if (i_bit_valid) begin
      shift_d = shift_nxt;
      if (hit) begin
        // Overlap keeps the fill so the match tail can seed the next match.
        fill_d = i_overlap ? fill_q : '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pattern_q <= DEF_PATTERN;
      shift_q   <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      shift_q   <= shift_d;
      fill_q    <= fill_d;
      det_q     <= hit;
    end
  end

  assign o_seq_detected = det_q;

  match_window_counter #(
    .CNT_W (CNT_W)
  ) u_window (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_inc        (hit),
    .i_tick       (i_tick),
    .o_count      (o_match_count),
    .o_disp_count (o_disp_count),
    .o_disp_valid (o_disp_valid),
    .o_disp_sat   (o_disp_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed table-driven bench for seq_pattern_detector plus hand-written
// saturation, tick and asynchronous-reset sequences.
module tb_seq_pattern_detector;

  localparam logic [8:0] DEFP = 9'b011101010;
  localparam logic [8:0] P1   = 9'b101010101;
  localparam logic [8:0] ONES = 9'b111111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_valid, bit_seq, pat_load, overlap, tick;
  logic [8:0] pattern;
  logic       det;
  logic [7:0] match_count, disp_count;
  logic       disp_valid, disp_sat;

  seq_pattern_detector #(
    .PAT_W       (9),
    .CNT_W       (8),
    .DEF_PATTERN (DEFP)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_bit_valid    (bit_valid),
    .i_bit_seq      (bit_seq),
    .i_pat_load     (pat_load),
    .i_pattern      (pattern),
    .i_overlap      (overlap),
    .i_tick         (tick),
    .o_seq_detected (det),
    .o_match_count  (match_count),
    .o_disp_count   (disp_count),
    .o_disp_valid   (disp_valid),
    .o_disp_sat     (disp_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic       b;
    logic       load;
    logic [8:0] pat;
    logic       ovl;
    logic       tck;
    logic       edet;
    logic [7:0] ecnt;
    logic       edv;
    logic [7:0] edc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cur_dc;
  int         tests;
  int         fails;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input int vld, input int b, input int load, input logic [8:0] pat,
                     input int ovl, input int tck, input int edet, input int ecnt, input int edc);
    vec_t v;
    if (tck != 0) cur_dc = 8'(edc);
    v.vld  = (vld != 0);
    v.b    = (b != 0);
    v.load = (load != 0);
    v.pat  = pat;
    v.ovl  = (ovl != 0);
    v.tck  = (tck != 0);
    v.edet = (edet != 0);
    v.ecnt = 8'(ecnt);
    v.edv  = (tck != 0);
    v.edc  = cur_dc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic vld, input logic b, input logic load, input logic [8:0] pat,
                       input logic ovl, input logic tck);
    @(negedge clk);
    bit_valid = vld;
    bit_seq   = b;
    pat_load  = load;
    pattern   = pat;
    overlap   = ovl;
    tick      = tck;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] w;
    tests     = 0;
    fails     = 0;
    cur_dc    = 8'd0;
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    bit_seq   = 1'b0;
    pat_load  = 1'b0;
    pattern   = P1;
    overlap   = 1'b1;
    tick      = 1'b0;
    w         = DEFP;

    // A: default pattern after reset, single match on the 9th bit.
    for (int i = 8; i >= 0; i--) add(1, int'(w[i]), 0, P1, 1, 0, int'(i == 0), int'(i == 0), 0);
    add(0, 0, 0, P1, 1, 1, 0, 0, 1);
    add(0, 0, 0, P1, 1, 0, 0, 0, 0);
    // B: same stream with a 3-cycle invalid gap carrying garbage.
    for (int i = 8; i >= 5; i--) add(1, int'(w[i]), 0, P1, 1, 0, 0, 0, 0);
    add(0, 1, 0, P1, 1, 0, 0, 0, 0);
    add(0, 0, 0, P1, 1, 0, 0, 0, 0);
    add(0, 1, 0, P1, 1, 0, 0, 0, 0);
    for (int i = 4; i >= 0; i--) add(1, int'(w[i]), 0, P1, 1, 0, int'(i == 0), int'(i == 0), 0);
    add(0, 0, 0, P1, 1, 1, 0, 0, 1);
    // C: load 101010101 with a discarded bit, 11 alternating bits, overlap on.
    add(1, 1, 1, P1, 1, 0, 0, 0, 0);
    for (int j = 0; j < 11; j++)
      add(1, int'(j % 2 == 0), 0, P1, 1, 0, int'(j == 8 || j == 10), (j < 8) ? 0 : ((j < 10) ? 1 : 2), 0);
    add(0, 0, 0, P1, 1, 1, 0, 0, 2);
    // D: same with overlap off.
    add(0, 0, 1, P1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 11; j++)
      add(1, int'(j % 2 == 0), 0, P1, 0, 0, int'(j == 8), int'(j >= 8), 0);
    add(0, 0, 0, P1, 0, 1, 0, 0, 1);
    // E: load after 5 bits; old prefix plus new bits must not match.
    add(0, 0, 1, P1, 1, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) add(1, int'(j % 2 == 0), 0, P1, 1, 0, 0, 0, 0);
    add(1, 0, 1, P1, 1, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) add(1, int'(j % 2 == 1), 0, P1, 1, 0, 0, 0, 0);
    // F: five matches, then a sixth coinciding with the tick.
    add(0, 0, 1, P1, 1, 0, 0, 0, 0);
    for (int j = 0; j < 18; j++)
      add(1, int'(j % 2 == 0), 0, P1, 1, 0, int'(j >= 8 && j % 2 == 0), (j < 8) ? 0 : ((j - 8) / 2 + 1), 0);
    add(1, 1, 0, P1, 1, 1, 1, 0, 6);
    add(0, 0, 0, P1, 1, 0, 0, 0, 0);

    #12;
    chk("rst_det", 0, 32'(det), 32'd0);
    chk("rst_cnt", 0, 32'(match_count), 32'd0);
    chk("rst_dcnt", 0, 32'(disp_count), 32'd0);
    chk("rst_dvld", 0, 32'(disp_valid), 32'd0);
    chk("rst_dsat", 0, 32'(disp_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vld, vecs[i].b, vecs[i].load, vecs[i].pat, vecs[i].ovl, vecs[i].tck);
      chk("det", i, 32'(det), 32'(vecs[i].edet));
      chk("cnt", i, 32'(match_count), 32'(vecs[i].ecnt));
      chk("dvld", i, 32'(disp_valid), 32'(vecs[i].edv));
      chk("dcnt", i, 32'(disp_count), 32'(vecs[i].edc));
      chk("dsat", i, 32'(disp_sat), 32'd0);
    end

    // Saturation: all-ones pattern with overlap gives one match per bit from bit 9.
    drive(1'b0, 1'b0, 1'b1, ONES, 1'b1, 1'b0);
    for (int j = 0; j < 308; j++) drive(1'b1, 1'b1, 1'b0, ONES, 1'b1, 1'b0);
    chk("sat_det", 0, 32'(det), 32'd1);
    chk("sat_cnt", 0, 32'(match_count), 32'd255);
    drive(1'b0, 1'b0, 1'b0, ONES, 1'b1, 1'b1);
    chk("sat_dcnt", 0, 32'(disp_count), 32'd255);
    chk("sat_dsat", 0, 32'(disp_sat), 32'd1);
    chk("sat_dvld", 0, 32'(disp_valid), 32'd1);
    chk("sat_cnt0", 0, 32'(match_count), 32'd0);
    drive(1'b0, 1'b0, 1'b0, ONES, 1'b1, 1'b0);
    chk("sat_dvld", 1, 32'(disp_valid), 32'd0);
    chk("sat_dhold", 0, 32'(disp_count), 32'd255);

    // Asynchronous reset after 6 bits of the default pattern.
    drive(1'b0, 1'b0, 1'b1, DEFP, 1'b1, 1'b0);
    for (int i = 8; i >= 3; i--) begin
      drive(1'b1, w[i], 1'b0, DEFP, 1'b1, 1'b0);
      chk("pre_rst_det", i, 32'(det), 32'd0);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_det", 0, 32'(det), 32'd0);
    chk("arst_cnt", 0, 32'(match_count), 32'd0);
    chk("arst_dcnt", 0, 32'(disp_count), 32'd0);
    chk("arst_dvld", 0, 32'(disp_valid), 32'd0);
    chk("arst_dsat", 0, 32'(disp_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, w[i], 1'b0, DEFP, 1'b1, 1'b0);
      chk("post_rst_tail", i, 32'(det), 32'd0);
    end
    for (int i = 8; i >= 0; i--) begin
      drive(1'b1, w[i], 1'b0, DEFP, 1'b1, 1'b0);
      chk("post_rst_det", i, 32'(det), 32'(i == 0));
      chk("post_rst_cnt", i, 32'(match_count), 32'(i == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised successor to the fixed 9-bit birthday receiver. It monitors a qualified serial bit stream and flags every occurrence of a runtime-loadable PAT_W-bit pattern, with overlapping or non-overlapping detection. Matches are counted in a saturating counter, which is latched for display and cleared on each external one-second tick. It sits between the serial transmitter and the display driver.

## Interface
- PAT_W, 9: pattern length in bits, minimum 2.
- CNT_W, 8: match-counter width.
- DEF_PATTERN, 9'b011101010: pattern in force after reset. The first received bit is the MSB.
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  reset. Asynchronous assert, active-low. Release is synchronous to i_clk externally.
- i_bit_valid  in  1  qualifies i_bit_seq. The bit is sampled only when this is high.
- i_bit_seq  in  1  serial data bit.
- i_pat_load  in  1  one-cycle strobe that loads i_pattern.
- i_pattern  in  PAT_W  new pattern, MSB first-received.
- i_overlap  in  1  1 = overlapping detection; 0 = non-overlapping. Level input, sampled on every match.
- i_tick  in  1  one-cycle window strobe (1 Hz enable from the timebase).
- o_seq_detected  out  1  registered one-cycle pulse per match.
- o_match_count  out  CNT_W  live matches in the current window.
- o_disp_count  out  CNT_W  count of the last closed window.
- o_disp_valid  out  1  one-cycle pulse when o_disp_count updates.
- o_disp_sat  out  1  the last closed window saturated.

## Operation
- Registers:
  - pattern reg, PAT_W bits
  - shift reg, PAT_W bits
  - fill counter, 0..PAT_W, saturating
  - match count, CNT_W bits
  - sat flag
  - display regs
- Valid bit:
  - shift reg becomes {shift[PAT_W-2:0], i_bit_seq}.
  - fill increments, saturating at PAT_W.
- hit (combinational): i_bit_valid, and fill ≥ PAT_W-1, and the next shift value equals the pattern reg.
- On hit:
  - o_seq_detected is 1 next cycle.
  - match count increments, saturating at 2^CNT_W-1.
  - An increment attempted at max sets the sat flag.
- Overlap handling on hit:
  - i_overlap=1: fill is unchanged, so trailing bits can start the next match.
  - i_overlap=0: fill goes to 0, so the next match needs PAT_W fresh bits.
- i_pat_load:
  - pattern reg takes i_pattern; fill goes to 0.
  - A valid bit in the same cycle is discarded, and no hit is possible that cycle.
  - Match count and display regs are untouched.
- i_tick:
  - o_disp_count takes the count including any hit in the same cycle.
  - o_disp_sat takes the sat flag, including a saturation in the same cycle.
  - o_disp_valid pulses.
  - Match count and sat flag clear to 0.
- i_bit_valid=0: no state changes except tick and load handling.
- Reset values:
  - pattern = DEF_PATTERN; shift, fill, count and sat = 0.
  - o_seq_detected, o_match_count, o_disp_count, o_disp_valid, o_disp_sat = 0.
- Reset mid-pattern discards all partial progress. The first match after release needs PAT_W valid bits.

## Timing
- Detection latency: exactly 1 cycle from the clock edge sampling the last pattern bit to o_seq_detected high.
- o_match_count reflects a hit on the same edge that raises o_seq_detected.
- o_disp_count and o_disp_valid update on the edge after the i_tick cycle. o_disp_count holds until the next tick.
- Back-to-back valid bits every cycle are supported. Maximum match rate is 1 per cycle in overlap mode with a self-overlapping pattern.
- A load takes effect for bits sampled from the cycle after the strobe.

## Structure
- Shared package seq_det_pkg holds:
  - DEF_PATTERN constant
  - FILL_W = $clog2(PAT_W+1) helper
  - CNT_MAX derived from CNT_W
- Sub-module match_window_counter holds the saturating counter, sat flag and tick-latched display registers.
  - Parameter: CNT_W.
  - Inputs: i_clk, i_rst_n, i_inc, i_tick.
  - Outputs: count, disp_count, disp_valid, disp_sat.
- Top-level keeps the pattern reg, shift reg, fill counter, compare and o_seq_detected register.

## Test plan
- Default pattern, reset only: stream valid bits 0,1,1,1,0,1,0,1,0 → single o_seq_detected pulse 1 cycle after the 9th bit; o_match_count = 1; no pulse during the first 8 bits.
- Load 9'b101010101, send 11 bits 1,0,1,0,1,0,1,0,1,0,1:
  - i_overlap=1 → pulses after bits 9 and 11, count = 2.
  - i_overlap=0 → pulse after bit 9 only, count = 1.
- Gaps: same default stream with i_bit_valid low for 3 cycles between bits 4 and 5, plus garbage on i_bit_seq while low → still exactly 1 match.
- Window/saturation with CNT_W=8: 300 overlap matches, then i_tick → o_disp_count = 255, o_disp_sat = 1, o_disp_valid 1-cycle pulse; o_match_count = 0 next cycle.
- Tick coincident with hit: count at 5, hit and i_tick in the same cycle → o_disp_count = 6, o_match_count = 0 afterwards.
- Reset and load mid-pattern:
  - Drop i_rst_n after 6 bits of the default pattern, asynchronously → all outputs 0 immediately; a full 9 bits after release is needed to match.
  - i_pat_load after 5 bits → no match from the old prefix.
